// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Brief    : Raster pixel stream to KxK sliding windows (stride 1, no padding).
//            Optional m_last output enabled by macro CONV_WINDOW_GEN_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
  parameter int ROWS        = 20,
  parameter int COLS        = 20,
  parameter int DEPTH       = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [DEPTH*DATA_WIDTH-1:0]                         s_data,
  input  logic                                                s_valid,
  output logic                                                s_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DEPTH*DATA_WIDTH-1:0] m_data,
  output logic                                                m_valid,
  input  logic                                                m_ready,
  output logic [$clog2(ROWS)-1:0]                             m_row,
  output logic [$clog2(COLS)-1:0]                             m_col,
`ifdef CONV_WINDOW_GEN_LAST_EN
  output logic                                                m_last,
`endif
  output logic                                                frame_done
);

  localparam int C_K     = KERNEL_SIZE;
  localparam int C_PIX_W = DEPTH*DATA_WIDTH;
  localparam int C_WIN_W = C_K*C_K*C_PIX_W;
  localparam int C_ROW_W = $clog2(ROWS);
  localparam int C_COL_W = $clog2(COLS);

  localparam logic [C_ROW_W-1:0] C_LAST_ROW = C_ROW_W'(ROWS-1);
  localparam logic [C_COL_W-1:0] C_LAST_COL = C_COL_W'(COLS-1);
  localparam logic [C_ROW_W-1:0] C_KM1_ROW  = C_ROW_W'(C_K-1);
  localparam logic [C_COL_W-1:0] C_KM1_COL  = C_COL_W'(C_K-1);

  logic [C_ROW_W-1:0] row_q, row_d;
  logic [C_COL_W-1:0] col_q, col_d;

  // Row 0 of the line buffer is the oldest stored row
  logic [C_PIX_W-1:0] lb_q  [C_K-1][COLS];
  logic [C_PIX_W-1:0] win_q [C_K][C_K];
  logic [C_PIX_W-1:0] win_d [C_K][C_K];
  logic [C_WIN_W-1:0] w_win_flat;

  logic               m_valid_q, m_valid_d;
  logic [C_WIN_W-1:0] m_data_q;
  logic [C_ROW_W-1:0] m_row_q;
  logic [C_COL_W-1:0] m_col_q;
  logic               frame_done_q;

  logic w_accept;
  logic w_emit;
  logic w_frame_end;

  assign s_ready     = !m_valid_q || m_ready;
  assign w_accept    = s_valid && s_ready && !rst;
  assign w_emit      = w_accept && (row_q >= C_KM1_ROW) && (col_q >= C_KM1_COL);
  assign w_frame_end = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (w_accept) begin
      if (col_q == C_LAST_COL) begin
        col_d = '0;
        row_d = (row_q == C_LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < C_K; r++) begin
      for (int c = 0; c < C_K-1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < C_K-1; r++) begin
      win_d[r][C_K-1] = lb_q[r][col_q];
    end
    win_d[C_K-1][C_K-1] = s_data;
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < C_K; r++) begin
      for (int c = 0; c < C_K; c++) begin
        w_win_flat[(r*C_K+c)*C_PIX_W +: C_PIX_W] = win_d[r][c];
      end
    end
  end

  // Acceptance implies any held window is consumed this cycle
  always_comb begin
    if (w_emit) begin
      m_valid_d = 1'b1;
    end else if (w_accept || m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // Storage only; contents are don't-care until refilled after reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < C_K-2; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[C_K-2][col_q] <= s_data;
      win_q              <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q        <= '0;
      col_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_row_q      <= '0;
      m_col_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      m_valid_q    <= m_valid_d;
      frame_done_q <= w_accept && w_frame_end;
      if (w_emit) begin
        m_data_q <= w_win_flat;
        m_row_q  <= row_q - C_KM1_ROW;
        m_col_q  <= col_q - C_KM1_COL;
      end
    end
  end

`ifdef CONV_WINDOW_GEN_LAST_EN
  logic m_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_last_q <= 1'b0;
    end else if (w_emit) begin
      m_last_q <= w_frame_end;
    end
  end

  assign m_last = m_last_q;
`endif

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_row      = m_row_q;
  assign m_col      = m_col_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_gen
// Brief    : Directed self-checking bench for conv_window_gen; pixel (r,c) of
//            frame f carries f*1000 + r*COLS + c on every channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

  localparam int ROWS      = 20;
  localparam int COLS      = 20;
  localparam int DEPTH     = 8;
  localparam int K         = 3;
  localparam int DW        = 16;
  localparam int PIX_W     = DEPTH*DW;
  localparam int MW        = K*K*PIX_W;
  localparam int FRAME_PIX = ROWS*COLS;
  localparam int WCOLS     = COLS-K+1;
  localparam int WPF       = (ROWS-K+1)*WCOLS;
  localparam int CENTRE    = ((K*K)/2)*PIX_W;

  typedef logic [$clog2(ROWS)-1:0] row_t;
  typedef logic [$clog2(COLS)-1:0] col_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [PIX_W-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [MW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  row_t             m_row;
  col_t             m_col;
  logic             frame_done;
`ifdef CONV_WINDOW_GEN_LAST_EN
  logic             m_last;
`endif

  int            checks = 0;
  int            errors = 0;
  int            last_cnt;
  int            cap_centre[$];
  logic [MW-1:0] first_data;

  always #5 clk = ~clk;

  conv_window_gen #(
    .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .KERNEL_SIZE(K), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_row(m_row),
    .m_col(m_col),
`ifdef CONV_WINDOW_GEN_LAST_EN
    .m_last(m_last),
`endif
    .frame_done(frame_done)
  );

  function automatic logic [PIX_W-1:0] pix_word(input int v);
    pix_word = '0;
    for (int d = 0; d < DEPTH; d++) pix_word[d*DW +: DW] = DW'(v);
  endfunction

  function automatic logic [MW-1:0] exp_window(input int orow, input int ocol, input int off);
    exp_window = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        exp_window[(r*K+c)*PIX_W +: PIX_W] = pix_word(off + (orow+r)*COLS + ocol + c);
  endfunction

  // Drives a pixel stream and checks every window against the reference model
  task automatic stream(input int nframes, input bit rnd_rdy, input bit gapped,
                        input int max_pix, input bit drain,
                        output int nwin, output int nfd);
    int pix, wexp, cyc, limit, f, w, orow, ocol;
    bit prev_acc, prev_hold, prev_last, acc, done;
    logic [MW-1:0] held, expw;
    pix = 0; wexp = 0; cyc = 0; nwin = 0; nfd = 0; last_cnt = 0;
    prev_acc = 0; prev_hold = 0; prev_last = 0; done = 0;
    held = '0;
    limit = (max_pix < nframes*FRAME_PIX) ? max_pix : nframes*FRAME_PIX;
    cap_centre.delete();
    while (!done) begin
      @(negedge clk);
      m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (pix < limit) && (!gapped || (cyc % 2 == 0));
      s_data  = pix_word((pix / FRAME_PIX) * 1000 + pix % FRAME_PIX);
      #1;
      if (m_valid === 1'b1) begin
        f = wexp / WPF; w = wexp % WPF; orow = w / WCOLS; ocol = w % WCOLS;
        expw = exp_window(orow, ocol, f*1000);
        checks++;
        if (m_data !== expw || m_row !== row_t'(orow) || m_col !== col_t'(ocol)) begin
          errors++;
          $display("FAIL window[%0d]: got row=%0d col=%0d centre=%0d, expected row=%0d col=%0d centre=%0d",
                   wexp, m_row, m_col, m_data[CENTRE +: DW], orow, ocol, expw[CENTRE +: DW]);
        end
        checks++;
        if (s_ready !== m_ready) begin
          errors++;
          $display("FAIL s_ready_follows_m_ready: got %b, expected %b", s_ready, m_ready);
        end
`ifdef CONV_WINDOW_GEN_LAST_EN
        checks++;
        if (m_last !== ((orow == ROWS-K) && (ocol == COLS-K))) begin
          errors++;
          $display("FAIL m_last[%0d]: got %b, expected %b", wexp, m_last,
                   (orow == ROWS-K) && (ocol == COLS-K));
        end
        if (m_ready && m_last === 1'b1) last_cnt++;
`endif
      end
      if (prev_hold) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++;
          $display("FAIL hold_stable[%0d]: got valid=%b centre=%0d, expected valid=1 centre=%0d",
                   wexp, m_valid, m_data[CENTRE +: DW], held[CENTRE +: DW]);
        end
      end
      checks++;
      if (m_valid === 1'b1 && !prev_acc && !prev_hold) begin
        errors++;
        $display("FAIL valid_without_accept: got m_valid=1, expected 0 (cycle %0d)", cyc);
      end
      checks++;
      if (frame_done !== prev_last) begin
        errors++;
        $display("FAIL frame_done: got %b, expected %b (cycle %0d)", frame_done, prev_last, cyc);
      end
      if (m_valid === 1'b1 && m_ready) begin
        cap_centre.push_back(int'(m_data[CENTRE +: DW]));
        if (wexp == 0) first_data = m_data;
        wexp++;
        nwin++;
      end
      nfd += int'(frame_done === 1'b1);
      prev_hold = (m_valid === 1'b1) && !m_ready;
      held      = m_data;
      acc       = s_valid && (s_ready === 1'b1);
      prev_last = acc && (pix % FRAME_PIX == FRAME_PIX-1);
      if (acc) pix++;
      prev_acc  = acc;
      cyc++;
      done = drain ? (pix >= limit && !acc && m_valid !== 1'b1) : (pix >= limit);
      if (cyc > 4*limit + 200) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: got %0d pixels after %0d cycles, expected %0d", pix, cyc, limit);
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
    checks++;
    if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got centre %0d, expected all zero", m_data[CENTRE +: DW]); end
    checks++;
    if (m_row !== '0 || m_col !== '0) begin errors++; $display("FAIL reset_row_col: got %0d/%0d, expected 0/0", m_row, m_col); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b, expected 1", s_ready); end
`ifdef CONV_WINDOW_GEN_LAST_EN
    checks++;
    if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b, expected 0", m_last); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_base_frame();
    int nwin, nfd, c0, cl;
    stream(1, 1'b0, 1'b0, FRAME_PIX, 1'b1, nwin, nfd);
    c0 = (cap_centre.size() > 0) ? cap_centre[0] : -1;
    cl = (cap_centre.size() > 0) ? cap_centre[cap_centre.size()-1] : -1;
    checks++;
    if (nwin != 324) begin errors++; $display("FAIL base_count: got %0d windows, expected 324", nwin); end
    checks++;
    if (c0 != 21) begin errors++; $display("FAIL base_first_centre: got %0d, expected 21", c0); end
    checks++;
    if (first_data[0 +: DW] !== 16'd0) begin errors++; $display("FAIL base_first_slot0: got %0d, expected 0", first_data[0 +: DW]); end
    checks++;
    if (first_data[8*PIX_W + 7*DW +: DW] !== 16'd42) begin
      errors++; $display("FAIL base_first_slot8_ch7: got %0d, expected 42", first_data[8*PIX_W + 7*DW +: DW]);
    end
    checks++;
    if (cl != 378) begin errors++; $display("FAIL base_last_centre: got %0d, expected 378", cl); end
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL base_frame_done_count: got %0d, expected 1", nfd); end
  endtask

  task automatic test_stall();
    int nwin, nfd;
    stream(1, 1'b1, 1'b0, FRAME_PIX, 1'b1, nwin, nfd);
    checks++;
    if (nwin != 324) begin errors++; $display("FAIL stall_count: got %0d windows, expected 324", nwin); end
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL stall_frame_done_count: got %0d, expected 1", nfd); end
  endtask

  task automatic test_back_to_back();
    int nwin, nfd, c324;
    stream(2, 1'b0, 1'b0, 2*FRAME_PIX, 1'b1, nwin, nfd);
    c324 = (cap_centre.size() > 324) ? cap_centre[324] : -1;
    checks++;
    if (nwin != 648) begin errors++; $display("FAIL b2b_count: got %0d windows, expected 648", nwin); end
    checks++;
    if (c324 != 1021) begin errors++; $display("FAIL b2b_window325_centre: got %0d, expected 1021", c324); end
    checks++;
    if (nfd != 2) begin errors++; $display("FAIL b2b_frame_done_count: got %0d, expected 2", nfd); end
  endtask

  task automatic test_mid_reset();
    int nwin, nfd, c0;
    stream(1, 1'b0, 1'b0, 7*COLS + 6, 1'b0, nwin, nfd);
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b1; m_ready = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b1 || m_row !== row_t'(5) || m_col !== col_t'(3)) begin
      errors++; $display("FAIL midrst_pending: got valid=%b row=%0d col=%0d, expected 1/5/3", m_valid, m_row, m_col);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_row !== '0 || m_col !== '0) begin
      errors++; $display("FAIL midrst_cleared: got valid=%b row=%0d col=%0d, expected 0/0/0", m_valid, m_row, m_col);
    end
    stream(1, 1'b0, 1'b0, FRAME_PIX, 1'b1, nwin, nfd);
    c0 = (cap_centre.size() > 0) ? cap_centre[0] : -1;
    checks++;
    if (nwin != 324) begin errors++; $display("FAIL midrst_count: got %0d windows, expected 324", nwin); end
    checks++;
    if (c0 != 21) begin errors++; $display("FAIL midrst_first_centre: got %0d, expected 21", c0); end
  endtask

  task automatic test_gapped();
    int nwin, nfd, cl;
    stream(1, 1'b0, 1'b1, FRAME_PIX, 1'b1, nwin, nfd);
    cl = (cap_centre.size() > 0) ? cap_centre[cap_centre.size()-1] : -1;
    checks++;
    if (nwin != 324) begin errors++; $display("FAIL gapped_count: got %0d windows, expected 324", nwin); end
    checks++;
    if (cl != 378) begin errors++; $display("FAIL gapped_last_centre: got %0d, expected 378", cl); end
    checks++;
    if (nfd != 1) begin errors++; $display("FAIL gapped_frame_done_count: got %0d, expected 1", nfd); end
  endtask

`ifdef CONV_WINDOW_GEN_LAST_EN
  task automatic test_last_flag();
    int nwin, nfd;
    stream(1, 1'b1, 1'b0, FRAME_PIX, 1'b1, nwin, nfd);
    checks++;
    if (last_cnt != 1) begin errors++; $display("FAIL m_last_count: got %0d, expected 1", last_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_base_frame();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_gapped();
`ifdef CONV_WINDOW_GEN_LAST_EN
    test_last_flag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
